// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer. One full-adder slice, built from two half-add
// cells and an OR, is stepped LSB-first over WIDTH clock edges. The result
// shifts into sum from the top so that after WIDTH steps bit 0 sits at sum[0].
// Handshake: ready in IDLE, busy in RUN, a one-cycle done pulse in FIN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;

  logic [1:0]       ha0;
  logic [1:0]       ha1;
  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] sum_nxt;
  logic             accept;
  logic             last_step;

  // Half-add cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  assign accept    = (state == S_IDLE) && start;
  assign last_step = (state == S_RUN) && (cnt == LAST);

  // Full-adder slice from two half-add cells; also forms the shifted sum.
  always_comb begin
    ha0              = half_add(sa[0], sb[0]);
    ha1              = half_add(ha0[0], carry);
    s_bit            = ha1[0];
    c_bit            = ha0[1] | ha1[1];
    sum_nxt          = sum >> 1;
    sum_nxt[WIDTH-1] = s_bit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> FIN on last bit, FIN -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state, mutually exclusive by construction.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_RUN:   busy  = 1'b1;
      S_FIN:   done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Bit counter, carry and result registers; reset discards any add in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == S_RUN) begin
      sum   <= sum_nxt;
      carry <= c_bit;
      cnt   <= cnt + CNT_W'(1);
      if (last_step) cout <= c_bit;
    end
  end

  // Operand shift registers: loaded on accept, shifted right every RUN step.
  always_ff @(posedge clk) begin
    if (accept) begin
      sa <= a;
      sb <= b;
    end else if (state == S_RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a WIDTH=8 instance driven by directed and random
// stimulus against a cycle-level reference model with an expected-result queue,
// plus a WIDTH=1 instance exercised over all four operand pairs.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         ready1, busy1, done1, cout1;
  logic [0:0]   sum1;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state (updated right after each rising edge by the driver).
  int           edge_n   = 0;
  int           next_acc = 0;
  int           acc_edge = 0;
  bit           acc_valid = 0;
  int           rst_edge = -1;
  logic [W:0]   pending  = '0;
  logic [W:0]   held     = '0;
  logic [W:0]   exp_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, edge_n);
  endtask

  // One clock of stimulus plus the model's view of what that edge did.
  task automatic step(input logic r, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    rst = r; start = s; a = x; b = y;
    @(posedge clk);
    edge_n++;
    if (r) begin
      exp_q.delete();
      acc_valid = 0;
      next_acc  = edge_n + 1;
      held      = '0;
      rst_edge  = edge_n;
    end else begin
      if (acc_valid && edge_n == acc_edge + W) held = pending;
      if (s && edge_n >= next_acc) begin
        pending   = {1'b0, x} + {1'b0, y};
        exp_q.push_back(pending);
        acc_valid = 1;
        acc_edge  = edge_n;
        next_acc  = edge_n + W + 2;
      end
    end
  endtask

  // Monitor: compares handshake timing every cycle, pops the scoreboard on done.
  initial begin
    logic [W:0] e;
    bit busy_e, done_e, ready_e;
    forever begin
      @(negedge clk);
      if (edge_n > 0) begin
        busy_e  = acc_valid && edge_n >= acc_edge && edge_n <= acc_edge + W - 1;
        done_e  = acc_valid && edge_n == acc_edge + W;
        ready_e = (edge_n + 1 >= next_acc);
        chk("ready", 64'(ready), 64'(ready_e));
        chk("busy",  64'(busy),  64'(busy_e));
        chk("done",  64'(done),  64'(done_e));
        if (done === 1'b1) begin
          if (exp_q.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            chk("result", 64'({cout, sum}), 64'(e));
          end
        end
        if (ready_e) chk("hold", 64'({cout, sum}), 64'(held));
        if (edge_n == rst_edge) chk("reset_sum", 64'({cout, sum}), 64'(0));
      end
    end
  end

  initial begin
    logic [W-1:0] x, y;
    logic [1:0]   pr;
    logic [7:0]   d_a [4];
    logic [7:0]   d_b [4];
    int           seen;
    d_a = '{8'h00, 8'hFF, 8'hA5, 8'h80};
    d_b = '{8'h00, 8'h01, 8'h5A, 8'h80};

    step(1, 0, '0, '0);
    step(1, 0, '0, '0);

    // Directed operand pairs with idle gaps.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, d_a[i], d_b[i]);
      repeat (11) step(0, 0, '0, '0);
    end

    // Start pulsed mid-add must be ignored.
    step(0, 1, 8'h0F, 8'h01);
    repeat (3) step(0, 0, '0, '0);
    step(0, 1, 8'hFF, 8'hFF);
    repeat (8) step(0, 0, '0, '0);

    // Reset mid-add, then a fresh add.
    step(0, 1, 8'h55, 8'hAA);
    repeat (4) step(0, 0, '0, '0);
    step(1, 0, '0, '0);
    step(0, 1, 8'h03, 8'h04);
    repeat (11) step(0, 0, '0, '0);

    // Start held high: back-to-back adds.
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom);
      step(0, 1, x, y);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      x = W'($urandom); y = W'($urandom);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), x, y);
    end

    repeat (12) step(0, 0, '0, '0);
    chk("drain", 64'(exp_q.size()), 64'(0));

    // WIDTH=1 instance: accept, one RUN edge, done.
    for (int i = 0; i < 4; i++) begin
      pr = 2'(i);
      @(negedge clk);
      start1 = 1'b1; a1 = pr[1]; b1 = pr[0];
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", 64'(busy1), 64'(1));
      seen = 0;
      for (int k = 0; k < 4 && seen == 0; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (done1 === 1'b1) begin
          seen = k + 1;
          chk("w1_result", 64'({cout1, sum1}), 64'({1'b0, pr[1]} + {1'b0, pr[0]}));
        end
      end
      chk("w1_latency", 64'(seen), 64'(1));
      @(posedge clk);
      @(negedge clk);
      chk("w1_ready", 64'(ready1), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
